bg_estimator: RTL and testbench
===============================

Name: bg_estimator

Overview:
- Upstream stage of the background-removal processing element (pe).
- Averages a programmable number of reference background pixels per channel and produces red_exp, green_exp and blue_exp for pe's expected-background inputs.
- Accumulates streamed RGB samples, then runs a 16-cycle sequential restoring division per channel, with all three channels in parallel.
- Holds the result in a done state until it is acknowledged. The Ack handshake and one-hot state outputs follow the same pattern as pe.

Parameters:
- PIX_W, 8, bits per colour channel.
- ACC_W, 16, accumulator/dividend width. Must be at least PIX_W+8 so that 255 samples of 255 do not overflow.

Ports:
- Clk, input, 1, system clock. All logic updates on the rising edge.
- Reset, input, 1, synchronous, active-high. One clock; reset is synchronous and active-high.
- Start, input, 1, begin a new estimation. Sampled only in INIT.
- Ack, input, 1, consumer acknowledge. Sampled only in DONE.
- n_samples, input, 8, number of samples to average. Latched when Start is accepted.
- pix_valid, input, 1, a sample is present on red_in/green_in/blue_in.
- pix_ready, output, 1, block accepts samples. Equals Qacc.
- red_in, input, PIX_W, red sample.
- green_in, input, PIX_W, green sample.
- blue_in, input, PIX_W, blue sample.
- red_exp, output, PIX_W, registered floor(red_sum/n).
- green_exp, output, PIX_W, registered floor(green_sum/n).
- blue_exp, output, PIX_W, registered floor(blue_sum/n).
- Qi, output, 1, state INIT.
- Qacc, output, 1, state ACC.
- Qdiv, output, 1, state DIV.
- Qd, output, 1, state DONE. Results are valid and stable while high.

Behaviour:
- Reset:
  - state=INIT, Qi=1, all other Q outputs 0, pix_ready=0.
  - Accumulators, sample counter, bit counter and n register cleared.
  - red_exp, green_exp and blue_exp = 0.
  - Reset has priority over every other input in every state, including mid-ACC and mid-DIV. Partial sums are discarded.
- Exactly one of Qi, Qacc, Qdiv, Qd is high in every cycle.
- INIT:
  - If Start=1 and n_samples!=0: latch n, clear the three accumulators and the sample counter, go to ACC.
  - If Start=1 and n_samples==0: ignore Start and stay in INIT.
  - Outputs keep their previous values.
- ACC:
  - pix_ready=1.
  - On each edge with pix_valid=1, add each zero-extended channel to its ACC_W accumulator and increment the counter.
  - On the edge that accepts the nth sample, go to DIV.
  - pix_valid=0 stalls with no change. No timeout.
  - Start is ignored.
- DIV:
  - Three restoring dividers run in parallel with dividend = accumulator and divisor = n (zero-extended).
  - Each divider generates one quotient bit per cycle, MSB first, over exactly ACC_W=16 cycles.
  - pix_valid and Start are ignored.
  - On the 16th DIV edge, write the low PIX_W quotient bits to the exp outputs and go to DONE.
  - The quotient is always ≤255 because the average of 8-bit values cannot exceed 255. The truncation to PIX_W bits is therefore lossless.
  - Rounding is floor; the remainder is discarded.
- DONE:
  - Qd=1 and outputs stay stable.
  - If Ack=1: go to INIT. Outputs keep their value until the next DIV completion.
  - If Ack=0: hold indefinitely.
  - Start is ignored.
- Latency: with pix_valid held high, Qd rises n+16 rising edges after the edge that samples Start.
- exp outputs change only on the DIV→DONE edge or on Reset.

Test Plan:
1. Reset held 5 cycles, then released. Required: Qi=1, pix_ready=0, exp outputs = 0,0,0. Start with n_samples=0 leaves the block in INIT.
2. n=4, four samples of (61,133,198) with pix_valid continuous. Required: Qd rises exactly 20 edges after Start is sampled; exp = (61,133,198).
3. n=4, red samples 10,20,30,41, green 0,0,0,3, blue 255,255,255,254. Required: exp = (25,0,254), which confirms floor rounding.
4. n=255, all samples (255,255,255), with pix_valid toggling every other cycle. Required: the block waits for exactly 255 accepted samples and then produces exp = (255,255,255) with no overflow.
5. Protocol checks:
   - Start pulsed in ACC, DIV and DONE has no effect.
   - Ack held low for 10 cycles keeps Qd and the outputs stable.
   - Ack then returns the block to INIT with the outputs retained.
   - A second run with n=1 and sample (7,8,9) gives (7,8,9).
6. Reset asserted mid-ACC (after 2 of 4 samples) and mid-DIV (cycle 8). Required: the block returns to INIT with exp = 0, and a following full n=2 run with samples (100,0,50) and (101,1,51) gives (100,0,50).

Source files
------------

// File: rtl/bg_estimator.sv
`default_nettype none
// ============================================================================
// Module  : bg_estimator
// Brief   : Averages n reference RGB samples per channel (floor) to produce the
//           expected-background values consumed by the pe stage.
// Revision: 1.0 - initial release
// ============================================================================
module bg_estimator #(
    parameter int PIX_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic [7:0]       n_samples,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] red_in,
    input  logic [PIX_W-1:0] green_in,
    input  logic [PIX_W-1:0] blue_in,
    output logic [PIX_W-1:0] red_exp,
    output logic [PIX_W-1:0] green_exp,
    output logic [PIX_W-1:0] blue_exp,
    output logic             Qi,
    output logic             Qacc,
    output logic             Qdiv,
    output logic             Qd
);

    localparam int c_NCH  = 3;
    localparam int c_BC_W = $clog2(ACC_W);
    localparam logic [c_BC_W-1:0] c_BIT_LAST = c_BC_W'(ACC_W - 1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_ACC  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [PIX_W-1:0]  w_pix      [c_NCH];
    logic [ACC_W-1:0]  r_acc      [c_NCH];
    logic [ACC_W-1:0]  r_rem      [c_NCH];
    logic [ACC_W-1:0]  w_acc_sum  [c_NCH];
    logic [ACC_W-1:0]  w_q_next   [c_NCH];
    logic [ACC_W-1:0]  w_rem_next [c_NCH];
    logic [PIX_W-1:0]  r_exp      [c_NCH];
    logic [7:0]        r_n;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_inc;
    logic [c_BC_W-1:0] r_bit_cnt;
    logic [ACC_W-1:0]  w_divisor;
    logic              w_start_ok;
    logic              w_last_sample;
    logic              w_div_last;

    assign w_pix[0] = red_in;
    assign w_pix[1] = green_in;
    assign w_pix[2] = blue_in;

    assign w_divisor     = ACC_W'(r_n);
    assign w_cnt_inc     = r_cnt + 8'd1;
    assign w_start_ok    = Start && (n_samples != 8'd0);
    assign w_last_sample = (r_state == S_ACC) && pix_valid && (w_cnt_inc == r_n);
    assign w_div_last    = (r_state == S_DIV) && (r_bit_cnt == c_BIT_LAST);

    // The accumulator doubles as the dividend/quotient shift register during DIV.
    generate
        for (genvar ch = 0; ch < c_NCH; ch++) begin : g_ch
            logic [ACC_W:0] w_trial;
            logic           w_qbit;
            assign w_trial        = {r_rem[ch], r_acc[ch][ACC_W-1]};
            assign w_qbit         = (w_trial >= {1'b0, w_divisor});
            assign w_rem_next[ch] = w_qbit ? ACC_W'(w_trial - {1'b0, w_divisor})
                                           : w_trial[ACC_W-1:0];
            assign w_q_next[ch]   = {r_acc[ch][ACC_W-2:0], w_qbit};
            assign w_acc_sum[ch]  = r_acc[ch] + ACC_W'(w_pix[ch]);
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_INIT;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        Qi           = 1'b0;
        Qacc         = 1'b0;
        Qdiv         = 1'b0;
        Qd           = 1'b0;
        case (r_state)
            S_INIT: begin
                Qi = 1'b1;
                if (w_start_ok) w_state_next = S_ACC;
            end
            S_ACC: begin
                Qacc = 1'b1;
                if (w_last_sample) w_state_next = S_DIV;
            end
            S_DIV: begin
                Qdiv = 1'b1;
                if (w_div_last) w_state_next = S_DONE;
            end
            default: begin
                Qd = 1'b1;
                if (Ack) w_state_next = S_INIT;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_n       <= '0;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            for (int ch = 0; ch < c_NCH; ch++) begin
                r_acc[ch] <= '0;
                r_rem[ch] <= '0;
                r_exp[ch] <= '0;
            end
        end else begin
            case (r_state)
                S_INIT: begin
                    if (w_start_ok) begin
                        r_n       <= n_samples;
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        for (int ch = 0; ch < c_NCH; ch++) begin
                            r_acc[ch] <= '0;
                            r_rem[ch] <= '0;
                        end
                    end
                end
                S_ACC: begin
                    if (pix_valid) begin
                        r_cnt <= w_cnt_inc;
                        for (int ch = 0; ch < c_NCH; ch++) r_acc[ch] <= w_acc_sum[ch];
                    end
                end
                S_DIV: begin
                    r_bit_cnt <= r_bit_cnt + c_BC_W'(1);
                    for (int ch = 0; ch < c_NCH; ch++) begin
                        r_acc[ch] <= w_q_next[ch];
                        r_rem[ch] <= w_rem_next[ch];
                        if (w_div_last) r_exp[ch] <= w_q_next[ch][PIX_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_ready = Qacc;
    assign red_exp   = r_exp[0];
    assign green_exp = r_exp[1];
    assign blue_exp  = r_exp[2];

endmodule
`default_nettype wire

// File: tb/tb_bg_estimator.sv
`default_nettype none
// ============================================================================
// Module  : tb_bg_estimator
// Brief   : Directed and randomized checks of bg_estimator against an
//           arithmetic averaging model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bg_estimator;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic [7:0] n_samples = 8'd0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [7:0] red_in = 8'd0;
    logic [7:0] green_in = 8'd0;
    logic [7:0] blue_in = 8'd0;
    logic [7:0] red_exp;
    logic [7:0] green_exp;
    logic [7:0] blue_exp;
    logic       Qi;
    logic       Qacc;
    logic       Qdiv;
    logic       Qd;

    int          tests = 0;
    int          fails = 0;
    int          sr [256];
    int          sg [256];
    int          sb [256];
    logic [23:0] prev_exp = 24'd0;

    bg_estimator #(.PIX_W(8), .ACC_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .n_samples(n_samples), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
        .Qi(Qi), .Qacc(Qacc), .Qdiv(Qdiv), .Qd(Qd)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic logic [23:0] cur_exp();
        return {red_exp, green_exp, blue_exp};
    endfunction

    task automatic set_sample(input int i, input int r, input int g, input int b);
        sr[i] = r; sg[i] = g; sb[i] = b;
    endtask

    // Runs one estimation with the samples in sr/sg/sb; exp_lat < 0 skips the latency check.
    task automatic run_est(input int n, input bit toggle, input int exp_lat);
        int rs, gs, bs, lat, idx, bound;
        logic [23:0] expected;
        rs = 0; gs = 0; bs = 0;
        for (int i = 0; i < n; i++) begin
            rs += sr[i]; gs += sg[i]; bs += sb[i];
        end
        expected = {8'(rs / n), 8'(gs / n), 8'(bs / n)};
        Start = 1'b1; n_samples = 8'(n); Ack = 1'b0; pix_valid = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        chk("acc_entry", {31'd0, Qacc}, 32'd1);
        lat = 0; idx = 0; bound = 2 * n + 40;
        while (Qd !== 1'b1 && lat < bound) begin
            chk("onehot", {31'd0, $onehot({Qi, Qacc, Qdiv, Qd})}, 32'd1);
            chk("exp_hold", {8'd0, cur_exp()}, {8'd0, prev_exp});
            if (idx < n && (!toggle || lat % 2 == 0)) begin
                pix_valid = 1'b1;
                red_in = 8'(sr[idx]); green_in = 8'(sg[idx]); blue_in = 8'(sb[idx]);
                idx++;
            end else begin
                pix_valid = (idx < n) ? 1'b0 : 1'($urandom % 2);
                red_in = 8'($urandom); green_in = 8'($urandom); blue_in = 8'($urandom);
            end
            Start = 1'($urandom % 2);
            n_samples = 8'($urandom);
            @(negedge Clk);
            lat++;
        end
        pix_valid = 1'b0; Start = 1'b0;
        chk("done_reached", {31'd0, Qd}, 32'd1);
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        chk("red_exp", {24'd0, red_exp}, {24'd0, expected[23:16]});
        chk("green_exp", {24'd0, green_exp}, {24'd0, expected[15:8]});
        chk("blue_exp", {24'd0, blue_exp}, {24'd0, expected[7:0]});
        prev_exp = expected;
    endtask

    task automatic ack_done();
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        chk("ack_to_init", {31'd0, Qi}, 32'd1);
        chk("exp_retained", {8'd0, cur_exp()}, {8'd0, prev_exp});
    endtask

    initial begin
        int n;

        // Reset and ignored zero-length Start
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_qi", {31'd0, Qi}, 32'd1);
        chk("rst_q_others", {29'd0, Qacc, Qdiv, Qd}, 32'd0);
        chk("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        chk("rst_exp", {8'd0, cur_exp()}, 32'd0);
        Start = 1'b1; n_samples = 8'd0;
        @(negedge Clk);
        Start = 1'b0;
        chk("n0_stays_init", {31'd0, Qi}, 32'd1);
        prev_exp = 24'd0;

        // Constant samples, latency n+16
        for (int i = 0; i < 4; i++) set_sample(i, 61, 133, 198);
        run_est(4, 1'b0, 20);
        ack_done();

        // Floor rounding
        set_sample(0, 10, 0, 255);
        set_sample(1, 20, 0, 255);
        set_sample(2, 30, 0, 255);
        set_sample(3, 41, 3, 254);
        run_est(4, 1'b0, 20);
        ack_done();

        // Full-scale 255 samples with gapped valid
        for (int i = 0; i < 255; i++) set_sample(i, 255, 255, 255);
        run_est(255, 1'b1, -1);

        // DONE holds with Ack low and Start pulses
        for (int k = 0; k < 10; k++) begin
            Start = (k % 2 == 0);
            n_samples = 8'd3;
            @(negedge Clk);
            chk("done_hold_qd", {31'd0, Qd}, 32'd1);
            chk("done_hold_exp", {8'd0, cur_exp()}, {8'd0, prev_exp});
        end
        Start = 1'b0;
        ack_done();

        set_sample(0, 7, 8, 9);
        run_est(1, 1'b0, 17);
        ack_done();

        // Randomized runs
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++)
                set_sample(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 255)));
            run_est(n, 1'(k % 2), (k % 2 == 1) ? -1 : n + 16);
            ack_done();
        end

        // Reset in the middle of accumulation
        Start = 1'b1; n_samples = 8'd4;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pix_valid = 1'b1; red_in = 8'd90; green_in = 8'd91; blue_in = 8'd92;
            @(negedge Clk);
        end
        pix_valid = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midacc_rst_qi", {31'd0, Qi}, 32'd1);
        chk("midacc_rst_exp", {8'd0, cur_exp()}, 32'd0);
        prev_exp = 24'd0;

        set_sample(0, 200, 100, 50);
        run_est(1, 1'b0, 17);
        ack_done();

        // Reset in the middle of division
        Start = 1'b1; n_samples = 8'd2;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pix_valid = 1'b1; red_in = 8'(i + 1); green_in = 8'(i + 2); blue_in = 8'(i + 3);
            @(negedge Clk);
        end
        pix_valid = 1'b0;
        chk("middiv_in_div", {31'd0, Qdiv}, 32'd1);
        repeat (7) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("middiv_rst_qi", {31'd0, Qi}, 32'd1);
        chk("middiv_rst_exp", {8'd0, cur_exp()}, 32'd0);
        repeat (3) @(negedge Clk);
        chk("middiv_stays_init", {31'd0, Qi}, 32'd1);
        prev_exp = 24'd0;

        set_sample(0, 100, 0, 50);
        set_sample(1, 101, 1, 51);
        run_est(2, 1'b0, 18);
        ack_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
